wb_regbank_slave: RTL

- Parametrised Wishbone classic-cycle slave. It bridges a host bus to a register file of N_REGS registers of DW bits each.
- Next-generation register front-end for the PWM/timer peripherals. Adds byte selects, configurable register count and stride, a read-latency wait state, error responses and read-only protection.
- Sits between the Wishbone interconnect and the peripheral reg_file.
- Emits one-cycle register strobes and exactly one ack or err pulse per bus request.

---
 rtl/wb_regbank_pkg.sv | 27 ++
 rtl/wb_regbank_slave_if.sv | 28 ++
 rtl/wb_adr_decode.sv | 43 ++++
 rtl/wb_regbank_slave.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/wb_regbank_pkg.sv
// wb_regbank_pkg: shared types and helpers for the Wishbone register-bank slave.
//   state_t  - front-end FSM states
//   RSP_*    - registered response encoding {err, ack}
//   clog2    - ceiling log2 for parameter arithmetic
package wb_regbank_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RESP    = 2'd2
  } state_t;

  localparam logic [1:0] RSP_NONE = 2'b00;
  localparam logic [1:0] RSP_ACK  = 2'b01;
  localparam logic [1:0] RSP_ERR  = 2'b10;

  // Width of the read-latency counter (RD_LAT is 0..7).
  localparam int unsigned LAT_W = 3;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/wb_regbank_slave_if.sv
// wb_regbank_slave_if: Wishbone classic bus bundle between host and slave.
//   master drives cyc/stb/we/adr/data/sel, slave drives ack/err/read data.
interface wb_regbank_slave_if #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 16
);

  logic          i_wb_cyc;
  logic          i_wb_stb;
  logic          i_wb_we;
  logic [AW-1:0] i_wb_adr;
  logic [DW-1:0] i_wb_data;
  logic [DW/8-1:0] i_wb_sel;
  logic          o_wb_ack;
  logic          o_wb_err;
  logic [DW-1:0] o_wb_data;

  modport master (
    output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_adr, i_wb_data, i_wb_sel,
    input  o_wb_ack, o_wb_err, o_wb_data
  );

  modport slave (
    input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_adr, i_wb_data, i_wb_sel,
    output o_wb_ack, o_wb_err, o_wb_data
  );

endinterface

// File: rtl/wb_adr_decode.sv
// wb_adr_decode: combinational byte-address to register-index decoder.
//   i_wb_adr     - byte address from the bus
//   i_wb_we      - write request flag
//   valid        - address hits an existing, aligned register
//   idx          - register index (meaningful when valid)
//   ro_violation - valid write aimed at a read-only register
module wb_adr_decode
  import wb_regbank_pkg::*;
#(
  parameter int unsigned         AW         = 16,
  parameter logic [AW-1:0]       BASE_ADR   = '0,
  parameter int unsigned         ADR_STRIDE = 2,
  parameter int unsigned         N_REGS     = 4,
  parameter logic [N_REGS-1:0]   RO_MASK    = '0,
  parameter int unsigned         IW         = 2
) (
  input  logic [AW-1:0] i_wb_adr,
  input  logic          i_wb_we,
  output logic          valid,
  output logic [IW-1:0] idx,
  output logic          ro_violation
);

  localparam int unsigned SH = clog2(ADR_STRIDE);

  logic [AW-1:0] off;
  logic [AW-1:0] slot;

  always_comb begin
    // Below-base is caught by the compare; the subtraction may wrap.
    off   = i_wb_adr - BASE_ADR;
    slot  = off >> SH;
    valid = (i_wb_adr >= BASE_ADR)
         && ((off & AW'(ADR_STRIDE - 1)) == '0)
         && (slot < AW'(N_REGS));
    idx   = slot[IW-1:0];
    ro_violation = 1'b0;
    for (int unsigned i = 0; i < N_REGS; i++) begin
      if (valid && i_wb_we && (slot == AW'(i))) ro_violation = RO_MASK[i];
    end
  end

endmodule

// File: rtl/wb_regbank_slave.sv
// wb_regbank_slave: Wishbone classic slave in front of a register file.
//   i_wb_clk/i_wb_rst - clock, synchronous active-high reset
//   wb               - Wishbone bus (slave modport)
//   i_reg_data       - read data from the register file
//   o_reg_idx/o_reg_data/o_reg_be - register index, write data, byte enables
//   o_reg_we/o_reg_re - one-cycle write/read strobes
// Every request gets exactly one ack or err pulse; reads wait RD_LAT cycles.
module wb_regbank_slave
  import wb_regbank_pkg::*;
#(
  parameter int unsigned       DW         = 16,
  parameter int unsigned       AW         = 16,
  parameter logic [AW-1:0]     BASE_ADR   = '0,
  parameter int unsigned       N_REGS     = 4,
  parameter int unsigned       ADR_STRIDE = 2,
  parameter int unsigned       RD_LAT     = 1,
  parameter logic [N_REGS-1:0] RO_MASK    = '0,
  localparam int unsigned      IW         = (clog2(N_REGS) < 1) ? 1 : clog2(N_REGS)
) (
  input  logic                i_wb_clk,
  input  logic                i_wb_rst,
  wb_regbank_slave_if.slave   wb,
  input  logic [DW-1:0]       i_reg_data,
  output logic [IW-1:0]       o_reg_idx,
  output logic [DW-1:0]       o_reg_data,
  output logic [DW/8-1:0]     o_reg_be,
  output logic                o_reg_we,
  output logic                o_reg_re
);

  state_t             state_q, state_d;
  logic [1:0]         rsp_q, rsp_d;
  logic [LAT_W-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]      rdata_q, rdata_d;
  logic [DW-1:0]      wdata_q, wdata_d;
  logic [DW/8-1:0]    be_q, be_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic               we_q, we_d;
  logic               re_q, re_d;

  logic               dec_valid;
  logic [IW-1:0]      dec_idx;
  logic               dec_ro;

  wb_adr_decode #(
    .AW         (AW),
    .BASE_ADR   (BASE_ADR),
    .ADR_STRIDE (ADR_STRIDE),
    .N_REGS     (N_REGS),
    .RO_MASK    (RO_MASK),
    .IW         (IW)
  ) u_dec (
    .i_wb_adr     (wb.i_wb_adr),
    .i_wb_we      (wb.i_wb_we),
    .valid        (dec_valid),
    .idx          (dec_idx),
    .ro_violation (dec_ro)
  );

  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      state_q <= IDLE;
      rsp_q   <= RSP_NONE;
      cnt_q   <= '0;
      rdata_q <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rsp_q   <= rsp_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      re_q    <= re_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rsp_d   = RSP_NONE;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    idx_d   = idx_q;
    we_d    = 1'b0;
    re_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (wb.i_wb_cyc && wb.i_wb_stb) begin
          if (!dec_valid || dec_ro) begin
            rsp_d   = RSP_ERR;
            state_d = RESP;
          end else if (wb.i_wb_we) begin
            idx_d   = dec_idx;
            wdata_d = wb.i_wb_data;
            be_d    = wb.i_wb_sel;
            we_d    = |wb.i_wb_sel;
            rsp_d   = RSP_ACK;
            state_d = RESP;
          end else begin
            idx_d   = dec_idx;
            re_d    = 1'b1;
            cnt_d   = LAT_W'(RD_LAT);
            state_d = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (!wb.i_wb_cyc) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          rdata_d = i_reg_data;
          rsp_d   = RSP_ACK;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign wb.o_wb_ack  = (rsp_q == RSP_ACK);
  assign wb.o_wb_err  = (rsp_q == RSP_ERR);
  assign wb.o_wb_data = rdata_q;
  assign o_reg_idx    = idx_q;
  assign o_reg_data   = wdata_q;
  assign o_reg_be     = be_q;
  assign o_reg_we     = we_q;
  assign o_reg_re     = re_q;

endmodule
